// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller, one half-adder pair per clock, LSB first,
// with a start/busy/done handshake and registered sum/carry_out.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ps_q, ps_d, sum_q, sum_d, ps_nx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d;
  logic             h1, g1, s, c_nx, last;
  always_comb begin
    h1      = a_q[0] ^ b_q[0];
    g1      = a_q[0] & b_q[0];
    s       = h1 ^ c_q;
    c_nx    = g1 | (h1 & c_q);
    ps_nx   = WIDTH'({s, ps_q} >> 1);
    last    = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ps_d    = ps_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == IDLE) begin
      if (start) begin
        a_d     = op_a;
        b_d     = op_b;
        ps_d    = '0;
        c_d     = 1'b0;
        cnt_d   = '0;
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      ps_d  = ps_nx;
      c_d   = c_nx;
      cnt_d = last ? cnt_q : cnt_q + 1'b1;
      if (last) begin
        sum_d   = ps_nx;
        cout_d  = c_nx;
        state_d = DONE;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ps_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ps_q    <= ps_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign busy      = state_q == RUN;
  assign done      = state_q == DONE;
  assign sum       = sum_q;
  assign carry_out = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: three widths (1, 8, 13) under directed and random traffic; a cycle-count
// protocol model plus a scoreboard of a+b results checks every DUT output on each falling edge.
module tb_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  st = '0;
  logic [12:0] a [3];
  logic [12:0] b [3];
  logic [2:0]  busy_v, done_v, co_v;
  logic [0:0]  s1;
  logic [7:0]  s8;
  logic [12:0] s13;
  logic [12:0] sv [3];
  logic [13:0] q [3][$];
  logic [13:0] last_r [3];
  int          ph [3];
  int          checks = 0;
  int          errors = 0;
  bit          final_mode = 1'b0;
  event        chk_ev;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .start(st[0]), .op_a(a[0][0:0]),
    .op_b(b[0][0:0]), .busy(busy_v[0]), .done(done_v[0]), .sum(s1), .carry_out(co_v[0]));
  serial_add_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(st[1]), .op_a(a[1][7:0]),
    .op_b(b[1][7:0]), .busy(busy_v[1]), .done(done_v[1]), .sum(s8), .carry_out(co_v[1]));
  serial_add_ctrl #(.WIDTH(13)) u13 (.clk(clk), .rst_n(rst_n), .start(st[2]), .op_a(a[2]),
    .op_b(b[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(s13), .carry_out(co_v[2]));

  assign sv[0] = {12'b0, s1};
  assign sv[1] = {5'b0, s8};
  assign sv[2] = s13;

  function automatic int wid(input int k);
    return k == 0 ? 1 : k == 1 ? 8 : 13;
  endfunction

  task automatic chk(input string n, input int w, input logic [13:0] got, input logic [13:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s w=%0d t=%0t got=%0h want=%0h", n, w, $time, got, want);
    end
  endtask

  // Reference: an accepted op is busy for w cycles then done for one; result is plain a+b.
  always @(negedge clk or chk_ev) begin
    for (int k = 0; k < 3; k++) begin
      int w;
      logic [13:0] m, got, exp;
      w   = wid(k);
      m   = (14'd1 << w) - 14'd1;
      got = {1'b0, sv[k]} | (14'(co_v[k]) << w);
      if (final_mode) begin
        chk("sb_drained", w, 14'(q[k].size()), 14'd0);
      end else if (!rst_n) begin
        chk("rst_busy", w, 14'(busy_v[k]), 14'd0);
        chk("rst_done", w, 14'(done_v[k]), 14'd0);
        chk("rst_result", w, got, 14'd0);
        ph[k] = 0;
        q[k].delete();
        last_r[k] = '0;
      end else begin
        chk("busy", w, 14'(busy_v[k]), 14'((ph[k] >= 1 && ph[k] <= w) ? 1 : 0));
        chk("done", w, 14'(done_v[k]), 14'((ph[k] == w + 1) ? 1 : 0));
        if (done_v[k]) begin
          if (q[k].size() == 0) begin
            chk("sb_empty", w, 14'd1, 14'd0);
          end else begin
            exp = q[k].pop_front();
            chk("result", w, got, exp);
            last_r[k] = exp;
          end
        end else begin
          chk("hold", w, got, last_r[k]);
        end
        if (ph[k] == 0 && st[k]) q[k].push_back((14'(a[k]) & m) + (14'(b[k]) & m));
        ph[k] = ph[k] == 0 ? (st[k] ? 1 : 0) : ph[k] == w + 1 ? 0 : ph[k] + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic op(input int k, input logic [12:0] x, input logic [12:0] y);
    a[k] = x;
    b[k] = y;
    st[k] = 1'b1;
    tick(1);
    st[k] = 1'b0;
    a[k] = 13'($urandom);
    b[k] = 13'($urandom);
    tick(wid(k) + 2);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      a[k] = '0;
      b[k] = '0;
      ph[k] = 0;
      last_r[k] = '0;
    end
    tick(3);
    rst_n = 1'b1;
    tick(1);
    op(0, 13'd0, 13'd0);
    op(0, 13'd0, 13'd1);
    op(0, 13'd1, 13'd0);
    op(0, 13'd1, 13'd1);
    op(1, 13'h0FF, 13'h001);
    op(1, 13'h0A5, 13'h05A);
    a[1] = 13'h011;
    b[1] = 13'h022;
    st[1] = 1'b1;
    tick(3);
    a[1] = 13'h0F0;
    b[1] = 13'h00F;
    tick(20);
    st[1] = 1'b0;
    tick(12);
    a[1] = 13'h077;
    b[1] = 13'h099;
    st[1] = 1'b1;
    tick(1);
    st[1] = 1'b0;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    -> chk_ev;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    op(1, 13'h012, 13'h034);
    tick(20);
    for (int i = 0; i < 9000; i++) begin
      for (int k = 0; k < 3; k++) begin
        st[k] = $urandom_range(0, 3) != 0;
        a[k] = 13'($urandom);
        b[k] = 13'($urandom);
      end
      tick(1);
    end
    st = '0;
    tick(20);
    final_mode = 1'b1;
    #1;
    -> chk_ev;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
